// File: rtl/lsu_pkg.sv
// LSU shared types: bus widths, access-size and FSM state encodings.
// Also holds the alignment check used at request acceptance.
package lsu_pkg;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SIZE_H: m = off[0];
      size == SIZE_W: m = |off;
      size == SIZE_X: m = 1'b1;
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extraction/extension and sub-word store merge (combinational).
// word_i: bus word, off_i: byte offset, size_i/uns_i: access; ld_o/st_o.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DW-1:0] word_i,
  input  logic [1:0]    off_i,
  input  logic [1:0]    size_i,
  input  logic          uns_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] ld_o,
  output logic [DW-1:0] st_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word_i[{off_i, 3'b000} +: 8];
    h    = word_i[{off_i[1], 4'b0000} +: 16];
    ld_o = word_i;
    st_o = word_i;
    case (size_i)
      SIZE_B: begin
        ld_o = {{24{~uns_i & b[7]}}, b};
        st_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        ld_o = {{16{~uns_i & h[15]}}, h};
        st_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ld_o = word_i;
        st_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time onto a simple word bus.
// Ports: req_* handshake in, resp_* pulse out, bus_* peripheral side.
module lsu
  import lsu_pkg::*;
#(
  parameter int BUS_RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_misalign,
  output logic          bus_rw,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [1:0] LAST = 2'(BUS_RD_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] word_q, word_d;
  logic          we_q, we_d;
  logic          uns_q, uns_d;
  logic          mis_q, mis_d;
  logic [DW-1:0] ld_data, st_data;

  lsu_align u_align (
    .word_i  (word_q),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .ld_o    (ld_data),
    .st_o    (st_data)
  );

  assign bus_addr = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    size_d        = size_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    we_d          = we_q;
    uns_d         = uns_q;
    mis_d         = mis_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_misalign = 1'b0;
    bus_rw        = 1'b0;
    bus_wdata     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          uns_d   = req_unsigned;
          cnt_d   = '0;
          mis_d   = is_misaligned(req_size, req_addr[1:0]);
          if (mis_d)
            state_d = RESP;
          else if (req_we && req_size == SIZE_W)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          word_d  = bus_rdata;
          cnt_d   = '0;
          // sub-word stores read-modify-write
          state_d = we_q ? WRITE : RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE: begin
        bus_rw     = 1'b1;
        bus_wdata  = st_data;
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      RESP: begin
        resp_valid    = 1'b1;
        resp_misalign = mis_q;
        resp_rdata    = mis_q ? '0 : ld_data;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: u0 at BUS_RD_LAT=1, u1 at BUS_RD_LAT=2.
// Both share stimulus; bus_rdata is held constant per access.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, bus_rdata;

  logic        rdy0, rv0, mis0, rw0;
  logic [31:0] rd0, ba0, bw0;
  logic        rdy1, rv1, mis1, rw1;
  logic [31:0] rd1, ba1, bw1;

  int n_chk = 0;
  int n_err = 0;
  int rwn0  = 0;
  int base;

  always #5 clk = ~clk;

  lsu #(.BUS_RD_LAT(1)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0),
    .resp_misalign(mis0),
    .bus_rw(rw0), .bus_addr(ba0),
    .bus_wdata(bw0), .bus_rdata(bus_rdata)
  );

  lsu #(.BUS_RD_LAT(2)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1),
    .resp_misalign(mis1),
    .bus_rw(rw1), .bus_addr(ba1),
    .bus_wdata(bw1), .bus_rdata(bus_rdata)
  );

  always @(negedge clk) if (rw0) rwn0++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // presents request in cycle T, returns at start of T+1
  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk);
    chk("rdy0", {31'd0, rdy0}, 32'd1);
    chk("rdy1", {31'd0, rdy1}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0);
    @(negedge clk);
    chk({tag, "_rv1"}, {31'd0, rv0}, 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_rv2"}, {31'd0, rv0}, 32'd1);
    chk({tag, "_rd"}, rd0, exp);
    chk({tag, "_mis"}, {31'd0, mis0}, 32'd0);
    gap(3);
  endtask

  task automatic st_chk(input string tag, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp);
    base = rwn0;
    issue(1'b1, sz, 1'b0, a, wd);
    if (sz != SIZE_W) begin
      @(negedge clk);
      chk({tag, "_rw_rd"}, {31'd0, rw0}, 32'd0);
      chk({tag, "_rv_rd"}, {31'd0, rv0}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk({tag, "_rw"}, {31'd0, rw0}, 32'd1);
    chk({tag, "_bw"}, bw0, exp);
    chk({tag, "_rv"}, {31'd0, rv0}, 32'd1);
    chk({tag, "_rd0"}, rd0, 32'd0);
    tick();
    chk({tag, "_npulse"}, rwn0 - base, 32'd1);
    @(negedge clk);
    chk({tag, "_rw_end"}, {31'd0, rw0}, 32'd0);
    chk({tag, "_rv_end"}, {31'd0, rv0}, 32'd0);
    gap(2);
  endtask

  task automatic mis_chk(input string tag, input logic we,
                         input logic [1:0] sz, input logic [31:0] a);
    base = rwn0;
    bus_rdata = 32'hA5A5_5A5A;
    issue(we, sz, 1'b0, a, 32'hFFFF_FFFF);
    @(negedge clk);
    chk({tag, "_rv"}, {31'd0, rv0}, 32'd1);
    chk({tag, "_mis"}, {31'd0, mis0}, 32'd1);
    chk({tag, "_rd"}, rd0, 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_rv_end"}, {31'd0, rv0}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, rdy0}, 32'd1);
    gap(2);
    chk({tag, "_npulse"}, rwn0 - base, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    bus_rdata = '0;
    gap(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, rdy0}, 32'd1);
    chk("rst_rv", {31'd0, rv0}, 32'd0);
    chk("rst_mis", {31'd0, mis0}, 32'd0);
    chk("rst_rd", rd0, 32'd0);
    chk("rst_rw", {31'd0, rw0}, 32'd0);
    chk("rst_ba", ba0, 32'd0);
    chk("rst_bw", bw0, 32'd0);
    tick();

    // word load; a request offered while busy must be dropped
    base = rwn0;
    bus_rdata = 32'h8899_AABB;
    issue(1'b0, SIZE_W, 1'b0, 32'h104, 32'h0);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h300;
    @(negedge clk);
    chk("wl_ba", ba0, 32'h104);
    chk("wl_rv1", {31'd0, rv0}, 32'd0);
    chk("wl_busy", {31'd0, rdy0}, 32'd0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("wl_rv2", {31'd0, rv0}, 32'd1);
    chk("wl_rd", rd0, 32'h8899_AABB);
    chk("wl_ba2", ba0, 32'h104);
    tick();
    @(negedge clk);
    chk("wl_rv3", {31'd0, rv0}, 32'd0);
    gap(3);
    chk("wl_npulse", rwn0 - base, 32'd0);

    bus_rdata = 32'h80FF_7F01;
    load_chk("lb_s", SIZE_B, 1'b0, 32'h107, 32'hFFFF_FF80);
    load_chk("lb_u", SIZE_B, 1'b1, 32'h107, 32'h0000_0080);
    load_chk("lb_0", SIZE_B, 1'b0, 32'h104, 32'h0000_0001);
    load_chk("lh_s", SIZE_H, 1'b0, 32'h106, 32'hFFFF_80FF);
    load_chk("lh_u", SIZE_H, 1'b1, 32'h104, 32'h0000_7F01);
    load_chk("lw_u", SIZE_W, 1'b1, 32'h104, 32'h80FF_7F01);

    bus_rdata = 32'h1122_3344;
    st_chk("sb", SIZE_B, 32'h102, 32'h0000_00A5, 32'h11A5_3344);
    st_chk("sh", SIZE_H, 32'h102, 32'h1234_BEEF, 32'hBEEF_3344);
    st_chk("sw", SIZE_W, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    mis_chk("mlh", 1'b0, SIZE_H, 32'h101);
    mis_chk("msw", 1'b1, SIZE_W, 32'h102);
    mis_chk("mx", 1'b0, SIZE_X, 32'h100);

    // reset during READ of a half store aborts it
    base = rwn0;
    bus_rdata = 32'h5566_7788;
    issue(1'b1, SIZE_H, 1'b0, 32'h200, 32'h0000_1234);
    @(negedge clk);
    chk("ra_ba", ba0, 32'h200);
    chk("ra_rw", {31'd0, rw0}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ra_rdy", {31'd0, rdy0}, 32'd1);
    chk("ra_rv", {31'd0, rv0}, 32'd0);
    chk("ra_ba0", ba0, 32'd0);
    gap(4);
    chk("ra_npulse", rwn0 - base, 32'd0);

    // latency 2, back-to-back word loads on u1
    bus_rdata = 32'hCAFE_F00D;
    issue(1'b0, SIZE_W, 1'b0, 32'h104, 32'h0);
    @(negedge clk);
    chk("l2a_rv1", {31'd0, rv1}, 32'd0);
    tick();
    @(negedge clk);
    chk("l2a_rv2", {31'd0, rv1}, 32'd0);
    tick();
    @(negedge clk);
    chk("l2a_rv3", {31'd0, rv1}, 32'd1);
    chk("l2a_rd", rd1, 32'hCAFE_F00D);
    tick();
    bus_rdata = 32'h0123_4567;
    issue(1'b0, SIZE_W, 1'b0, 32'h208, 32'h0);
    @(negedge clk);
    chk("l2b_ba", ba1, 32'h208);
    chk("l2b_rv1", {31'd0, rv1}, 32'd0);
    tick();
    @(negedge clk);
    chk("l2b_rv2", {31'd0, rv1}, 32'd0);
    tick();
    @(negedge clk);
    chk("l2b_rv3", {31'd0, rv1}, 32'd1);
    chk("l2b_rd", rd1, 32'h0123_4567);
    tick();
    @(negedge clk);
    chk("l2b_rv4", {31'd0, rv1}, 32'd0);
    gap(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
